// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the load/store sequencer.
// Misaligned-access trap option: MEM_ACCESS_CTRL_MISALIGN_TRAP_EN.
package memory_system_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_DATA,
        RMW_ADDR,
        RMW_DATA,
        ST_WRITE
    } mem_ctrl_state_e;

    // Accept-to-response latency in cycles per access kind.
    localparam int MEM_LD_LATENCY  = 3;
    localparam int MEM_ST_LATENCY  = 2;
    localparam int MEM_RMW_LATENCY = 4;

    // Half needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic is_misaligned(mem_size_e size, logic [1:0] lo);
        return ((size == HALF) && lo[0]) ||
               ((size == WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-controller bundle of the sequencer.
// Adds rsp_fault_out when MEM_ACCESS_CTRL_MISALIGN_TRAP_EN is defined.
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = 5
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic                  req_we_in;
    logic [1:0]            req_size_in;
    logic                  req_unsigned_in;
    logic [ADDR_WIDTH-1:0] req_addr_in;
    logic [31:0]           req_wr_data_in;
    logic [IDX_WIDTH-1:0]  req_rd_idx_in;
    logic                  rsp_valid_out;
    logic [31:0]           rsp_data_out;
    logic [IDX_WIDTH-1:0]  rsp_rd_idx_out;
    logic                  rsp_we_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [31:0]           mem_wr_data_out;
    logic [31:0]           mem_rd_data_in;
    logic                  mem_we_out;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
    logic                  rsp_fault_out;

    modport slave (
        input  req_valid_in, req_we_in, req_size_in, req_unsigned_in,
        input  req_addr_in, req_wr_data_in, req_rd_idx_in, mem_rd_data_in,
        output req_ready_out, rsp_valid_out, rsp_data_out, rsp_rd_idx_out,
        output rsp_we_out, mem_addr_out, mem_wr_data_out, mem_we_out,
        output rsp_fault_out
    );

    modport master (
        output req_valid_in, req_we_in, req_size_in, req_unsigned_in,
        output req_addr_in, req_wr_data_in, req_rd_idx_in, mem_rd_data_in,
        input  req_ready_out, rsp_valid_out, rsp_data_out, rsp_rd_idx_out,
        input  rsp_we_out, mem_addr_out, mem_wr_data_out, mem_we_out,
        input  rsp_fault_out
    );
`else
    modport slave (
        input  req_valid_in, req_we_in, req_size_in, req_unsigned_in,
        input  req_addr_in, req_wr_data_in, req_rd_idx_in, mem_rd_data_in,
        output req_ready_out, rsp_valid_out, rsp_data_out, rsp_rd_idx_out,
        output rsp_we_out, mem_addr_out, mem_wr_data_out, mem_we_out
    );

    modport master (
        output req_valid_in, req_we_in, req_size_in, req_unsigned_in,
        output req_addr_in, req_wr_data_in, req_rd_idx_in, mem_rd_data_in,
        input  req_ready_out, rsp_valid_out, rsp_data_out, rsp_rd_idx_out,
        input  rsp_we_out, mem_addr_out, mem_wr_data_out, mem_we_out
    );
`endif

endinterface

// File: rtl/mem_access_ctrl_lane.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
// Little-endian: byte lane = addr[1:0], half lane = addr[1].
module mem_lane_align
    import memory_system_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  mem_size_e   i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane, extend it, and splice store data into it.
    always_comb begin
        w_byte    = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half    = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_ld_data = i_word;
        o_st_word = i_word;
        unique case (i_size)
            BYTE: begin
                o_ld_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                o_st_word[{i_addr_lo, 3'b000} +: 8] = i_st_data[7:0];
            end
            HALF: begin
                o_ld_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
                if (i_addr_lo[1]) begin
                    o_st_word[31:16] = i_st_data[15:0];
                end else begin
                    o_st_word[15:0] = i_st_data[15:0];
                end
            end
            default: begin
                o_ld_data = i_word;
                o_st_word = i_st_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute stage and single-port memory.
// Optional misaligned-access trap: define MEM_ACCESS_CTRL_MISALIGN_TRAP_EN.
module mem_access_ctrl
    import memory_system_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = 5
)
(
    input logic         clk_in,
    input logic         rst_high_in,
    mem_access_ctrl_if.slave bus
);

    mem_ctrl_state_e       r_state, w_state_nxt;
    mem_size_e             r_size;
    logic                  r_uns;
    logic [1:0]            r_addr_lo;
    logic [31:0]           r_wdata;
    logic [IDX_WIDTH-1:0]  r_idx;

    logic                  r_rsp_valid, w_rsp_valid;
    logic [31:0]           r_rsp_data, w_rsp_data;
    logic [IDX_WIDTH-1:0]  r_rsp_idx, w_rsp_idx;
    logic                  r_rsp_we, w_rsp_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
    logic [31:0]           r_mem_wdata, w_mem_wdata;
    logic                  r_mem_we, w_mem_we;

    logic                  w_accept;
    logic                  w_misalign;
    mem_size_e             w_req_size;
    logic [ADDR_WIDTH-1:0] w_req_waddr;
    logic [31:0]           w_ld_data;
    logic [31:0]           w_st_word;

    assign w_accept    = bus.req_valid_in && (r_state == IDLE);
    assign w_req_size  = mem_size_e'(bus.req_size_in);
    assign w_req_waddr = {bus.req_addr_in[ADDR_WIDTH-1:2], 2'b00};

`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
    logic r_rsp_fault, w_rsp_fault;
    assign w_misalign        = is_misaligned(w_req_size, bus.req_addr_in[1:0]);
    assign bus.rsp_fault_out = r_rsp_fault;
`else
    assign w_misalign = 1'b0;
`endif

    mem_lane_align u_lane (
        .i_word     (bus.mem_rd_data_in),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_st_data  (r_wdata),
        .o_ld_data  (w_ld_data),
        .o_st_word  (w_st_word)
    );

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_valid = 1'b0;
        w_rsp_data  = '0;
        w_rsp_idx   = '0;
        w_rsp_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_we    = 1'b0;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
        w_rsp_fault = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                w_mem_addr  = '0;
                w_mem_wdata = '0;
                if (w_accept) begin
                    if (w_misalign) begin
                        w_rsp_valid = 1'b1;
                        w_rsp_idx   = bus.req_rd_idx_in;
                        w_rsp_we    = bus.req_we_in;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
                        w_rsp_fault = 1'b1;
`endif
                    end else if (!bus.req_we_in) begin
                        w_state_nxt = LD_ADDR;
                        w_mem_addr  = w_req_waddr;
                    end else if (w_req_size == WORD) begin
                        w_state_nxt = ST_WRITE;
                        w_mem_addr  = w_req_waddr;
                        w_mem_wdata = bus.req_wr_data_in;
                        w_mem_we    = 1'b1;
                    end else begin
                        w_state_nxt = RMW_ADDR;
                        w_mem_addr  = w_req_waddr;
                    end
                end
            end
            LD_ADDR: w_state_nxt = LD_DATA;
            LD_DATA: begin
                w_state_nxt = IDLE;
                w_rsp_valid = 1'b1;
                w_rsp_data  = w_ld_data;
                w_rsp_idx   = r_idx;
                w_mem_addr  = '0;
            end
            RMW_ADDR: w_state_nxt = RMW_DATA;
            RMW_DATA: begin
                w_state_nxt = ST_WRITE;
                w_mem_wdata = w_st_word;
                w_mem_we    = 1'b1;
            end
            ST_WRITE: begin
                w_state_nxt = IDLE;
                w_rsp_valid = 1'b1;
                w_rsp_idx   = r_idx;
                w_rsp_we    = 1'b1;
                w_mem_addr  = '0;
                w_mem_wdata = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_mem_addr  = '0;
                w_mem_wdata = '0;
            end
        endcase
    end

    // State, captured request fields and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_high_in) begin
            r_state     <= IDLE;
            r_size      <= BYTE;
            r_uns       <= 1'b0;
            r_addr_lo   <= '0;
            r_wdata     <= '0;
            r_idx       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_idx   <= '0;
            r_rsp_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
            r_rsp_fault <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_idx   <= w_rsp_idx;
            r_rsp_we    <= w_rsp_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_we    <= w_mem_we;
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
            r_rsp_fault <= w_rsp_fault;
`endif
            if (w_accept) begin
                r_size    <= w_req_size;
                r_uns     <= bus.req_unsigned_in;
                r_addr_lo <= bus.req_addr_in[1:0];
                r_wdata   <= bus.req_wr_data_in;
                r_idx     <= bus.req_rd_idx_in;
            end
        end
    end

    assign bus.req_ready_out   = (r_state == IDLE);
    assign bus.rsp_valid_out   = r_rsp_valid;
    assign bus.rsp_data_out    = r_rsp_data;
    assign bus.rsp_rd_idx_out  = r_rsp_idx;
    assign bus.rsp_we_out      = r_rsp_we;
    assign bus.mem_addr_out    = r_mem_addr;
    assign bus.mem_wr_data_out = r_mem_wdata;
    assign bus.mem_we_out      = r_mem_we;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a one-cycle-latency memory model.
// Covers both builds of MEM_ACCESS_CTRL_MISALIGN_TRAP_EN.
module tb_mem_access_ctrl;
    import memory_system_pkg::*;

    localparam int AW = 32;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW)) bus ();

    mem_access_ctrl #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW)) dut (
        .clk_in      (clk),
        .rst_high_in (rst),
        .bus         (bus)
    );

    // Memory model: read data valid the cycle after the address.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        bus.mem_rd_data_in <= mem[bus.mem_addr_out[11:2]];
        if (bus.mem_we_out === 1'b1)
            mem[bus.mem_addr_out[11:2]] <= bus.mem_wr_data_out;
    end

    // Pulse counters sampled at the rising edge.
    int we_cnt  = 0;
    int rsp_cnt = 0;
    always @(posedge clk) begin
        if (bus.mem_we_out === 1'b1) we_cnt <= we_cnt + 1;
        if (bus.rsp_valid_out === 1'b1) rsp_cnt <= rsp_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [4:0] idx);
        bus.req_valid_in    = 1'b1;
        bus.req_we_in       = we;
        bus.req_size_in     = sz;
        bus.req_unsigned_in = uns;
        bus.req_addr_in     = addr;
        bus.req_wr_data_in  = wd;
        bus.req_rd_idx_in   = idx;
    endtask

    // Present one request at a negedge; return cycles until rsp_valid.
    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] idx,
                         output int lat);
        drive_req(we, sz, uns, addr, wd, idx);
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        lat = 1;
        while (bus.rsp_valid_out !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 12) lat = -1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  idx;
        logic [31:0] init;
        logic [31:0] exp_data;
        logic [31:0] exp_word;
        int          exp_lat;
        int          exp_wes;
    } vec_t;

    localparam int NV = 11;
    vec_t v [NV];

    initial begin
        int lat;
        int we0;
        int rsp0;

        v[0]  = '{1'b0, BYTE, 1'b0, 32'h103, 32'h0, 5'd7, 32'h8899AABB,
                  32'hFFFFFF88, 32'h8899AABB, MEM_LD_LATENCY, 0};
        v[1]  = '{1'b0, HALF, 1'b1, 32'h102, 32'h0, 5'd1, 32'h8899AABB,
                  32'h00008899, 32'h8899AABB, MEM_LD_LATENCY, 0};
        v[2]  = '{1'b0, BYTE, 1'b1, 32'h100, 32'h0, 5'd2, 32'h8899AABB,
                  32'h000000BB, 32'h8899AABB, MEM_LD_LATENCY, 0};
        v[3]  = '{1'b0, HALF, 1'b0, 32'h100, 32'h0, 5'd3, 32'h8899AABB,
                  32'hFFFFAABB, 32'h8899AABB, MEM_LD_LATENCY, 0};
        v[4]  = '{1'b0, WORD, 1'b0, 32'h100, 32'h0, 5'd4, 32'h8899AABB,
                  32'h8899AABB, 32'h8899AABB, MEM_LD_LATENCY, 0};
        v[5]  = '{1'b0, BYTE, 1'b1, 32'h102, 32'h0, 5'd5, 32'h8899AABB,
                  32'h00000099, 32'h8899AABB, MEM_LD_LATENCY, 0};
        v[6]  = '{1'b0, BYTE, 1'b0, 32'h101, 32'h0, 5'd31, 32'h8899AABB,
                  32'hFFFFFFAA, 32'h8899AABB, MEM_LD_LATENCY, 0};
        v[7]  = '{1'b1, WORD, 1'b0, 32'h200, 32'hDEADBEEF, 5'd8, 32'h0,
                  32'h0, 32'hDEADBEEF, MEM_ST_LATENCY, 1};
        v[8]  = '{1'b1, BYTE, 1'b0, 32'h301, 32'h123456CC, 5'd9,
                  32'h11223344, 32'h0, 32'h1122CC44, MEM_RMW_LATENCY, 1};
        v[9]  = '{1'b1, HALF, 1'b0, 32'h302, 32'h0000BEEF, 5'd10,
                  32'h11223344, 32'h0, 32'hBEEF3344, MEM_RMW_LATENCY, 1};
        v[10] = '{1'b1, BYTE, 1'b0, 32'h300, 32'h000000AB, 5'd11,
                  32'h11223344, 32'h0, 32'h112233AB, MEM_RMW_LATENCY, 1};

        bus.req_valid_in    = 1'b0;
        bus.req_we_in       = 1'b0;
        bus.req_size_in     = 2'b00;
        bus.req_unsigned_in = 1'b0;
        bus.req_addr_in     = '0;
        bus.req_wr_data_in  = '0;
        bus.req_rd_idx_in   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready_out), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
        check("rst_rsp_data", bus.rsp_data_out, 32'd0);
        check("rst_mem_we", 32'(bus.mem_we_out), 32'd0);
        check("rst_mem_addr", bus.mem_addr_out, 32'd0);
        check("rst_mem_wdata", bus.mem_wr_data_out, 32'd0);
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
        check("rst_fault", 32'(bus.rsp_fault_out), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            mem[v[i].addr[11:2]] = v[i].init;
            we0  = we_cnt;
            rsp0 = rsp_cnt;
            check($sformatf("v%0d_ready", i), 32'(bus.req_ready_out), 32'd1);
            issue(v[i].we, v[i].sz, v[i].uns, v[i].addr, v[i].wd,
                  v[i].idx, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].exp_lat));
            check($sformatf("v%0d_data", i), bus.rsp_data_out, v[i].exp_data);
            check($sformatf("v%0d_idx", i), 32'(bus.rsp_rd_idx_out),
                  32'(v[i].idx));
            check($sformatf("v%0d_rsp_we", i), 32'(bus.rsp_we_out),
                  32'(v[i].we));
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
            check($sformatf("v%0d_fault", i), 32'(bus.rsp_fault_out), 32'd0);
`endif
            @(negedge clk);
            check($sformatf("v%0d_rsp_drop", i), 32'(bus.rsp_valid_out), 32'd0);
            check($sformatf("v%0d_data_clr", i), bus.rsp_data_out, 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_word", i), mem[v[i].addr[11:2]],
                  v[i].exp_word);
            check($sformatf("v%0d_we_cnt", i), 32'(we_cnt - we0),
                  32'(v[i].exp_wes));
            check($sformatf("v%0d_rsp_cnt", i), 32'(rsp_cnt - rsp0), 32'd1);
        end

        // Word store cycle timing
        drive_req(1'b1, WORD, 1'b0, 32'h204, 32'hDEADBEEF, 5'd6);
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        check("sw_n1_we", 32'(bus.mem_we_out), 32'd1);
        check("sw_n1_addr", bus.mem_addr_out, 32'h204);
        check("sw_n1_wdata", bus.mem_wr_data_out, 32'hDEADBEEF);
        check("sw_n1_ready", 32'(bus.req_ready_out), 32'd0);
        @(negedge clk);
        check("sw_n2_rsp", 32'(bus.rsp_valid_out), 32'd1);
        check("sw_n2_rsp_we", 32'(bus.rsp_we_out), 32'd1);
        check("sw_n2_mem_we", 32'(bus.mem_we_out), 32'd0);
        check("sw_n2_addr", bus.mem_addr_out, 32'h0);
        @(negedge clk);

        // Sub-word store cycle timing
        mem[32'h300 >> 2] = 32'h11223344;
        drive_req(1'b1, BYTE, 1'b0, 32'h301, 32'h123456CC, 5'd12);
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        check("sb_n1_we", 32'(bus.mem_we_out), 32'd0);
        check("sb_n1_addr", bus.mem_addr_out, 32'h300);
        @(negedge clk);
        check("sb_n2_we", 32'(bus.mem_we_out), 32'd0);
        @(negedge clk);
        check("sb_n3_we", 32'(bus.mem_we_out), 32'd1);
        check("sb_n3_addr", bus.mem_addr_out, 32'h300);
        check("sb_n3_wdata", bus.mem_wr_data_out, 32'h1122CC44);
        check("sb_n3_rsp", 32'(bus.rsp_valid_out), 32'd0);
        @(negedge clk);
        check("sb_n4_rsp", 32'(bus.rsp_valid_out), 32'd1);
        check("sb_n4_mem_we", 32'(bus.mem_we_out), 32'd0);
        @(negedge clk);

        // Back-to-back: LW then SW with valid held high
        mem[32'h100 >> 2] = 32'h8899AABB;
        rsp0 = rsp_cnt;
        drive_req(1'b0, WORD, 1'b0, 32'h100, 32'h0, 5'd13);
        @(negedge clk);
        check("b2b_n1_ready", 32'(bus.req_ready_out), 32'd0);
        drive_req(1'b1, WORD, 1'b0, 32'h208, 32'hCAFEF00D, 5'd14);
        @(negedge clk);
        check("b2b_n2_ready", 32'(bus.req_ready_out), 32'd0);
        @(negedge clk);
        check("b2b_n3_ready", 32'(bus.req_ready_out), 32'd1);
        check("b2b_n3_rsp", 32'(bus.rsp_valid_out), 32'd1);
        check("b2b_n3_data", bus.rsp_data_out, 32'h8899AABB);
        check("b2b_n3_idx", 32'(bus.rsp_rd_idx_out), 32'd13);
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        check("b2b_n4_we", 32'(bus.mem_we_out), 32'd1);
        check("b2b_n4_addr", bus.mem_addr_out, 32'h208);
        check("b2b_n4_rsp", 32'(bus.rsp_valid_out), 32'd0);
        @(negedge clk);
        check("b2b_n5_rsp", 32'(bus.rsp_valid_out), 32'd1);
        check("b2b_n5_rsp_we", 32'(bus.rsp_we_out), 32'd1);
        check("b2b_n5_idx", 32'(bus.rsp_rd_idx_out), 32'd14);
        repeat (2) @(negedge clk);
        check("b2b_rsp_cnt", 32'(rsp_cnt - rsp0), 32'd2);
        check("b2b_word", mem[32'h208 >> 2], 32'hCAFEF00D);

        // Reset in the middle of a sub-word store
        mem[32'h300 >> 2] = 32'h11223344;
        we0  = we_cnt;
        rsp0 = rsp_cnt;
        drive_req(1'b1, BYTE, 1'b0, 32'h302, 32'h00000077, 5'd15);
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rmid_ready", 32'(bus.req_ready_out), 32'd1);
        check("rmid_mem_we", 32'(bus.mem_we_out), 32'd0);
        check("rmid_rsp", 32'(bus.rsp_valid_out), 32'd0);
        check("rmid_addr", bus.mem_addr_out, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rmid_we_cnt", 32'(we_cnt - we0), 32'd0);
        check("rmid_rsp_cnt", 32'(rsp_cnt - rsp0), 32'd0);
        check("rmid_word", mem[32'h300 >> 2], 32'h11223344);

        // Reset overrides a request in the same cycle
        rsp0 = rsp_cnt;
        rst  = 1'b1;
        drive_req(1'b0, WORD, 1'b0, 32'h100, 32'h0, 5'd16);
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        rst = 1'b0;
        check("rovr_ready", 32'(bus.req_ready_out), 32'd1);
        check("rovr_addr", bus.mem_addr_out, 32'h0);
        repeat (4) @(negedge clk);
        check("rovr_rsp_cnt", 32'(rsp_cnt - rsp0), 32'd0);

        // Misaligned word load
        mem[32'h100 >> 2] = 32'h8899AABB;
        we0 = we_cnt;
        issue(1'b0, WORD, 1'b0, 32'h102, 32'h0, 5'd9, lat);
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_fault", 32'(bus.rsp_fault_out), 32'd1);
        check("mis_data", bus.rsp_data_out, 32'h0);
        check("mis_idx", 32'(bus.rsp_rd_idx_out), 32'd9);
        @(negedge clk);
        check("mis_fault_clr", 32'(bus.rsp_fault_out), 32'd0);
`else
        check("mis_lat", 32'(lat), 32'(MEM_LD_LATENCY));
        check("mis_data", bus.rsp_data_out, 32'h8899AABB);
        check("mis_idx", 32'(bus.rsp_rd_idx_out), 32'd9);
        @(negedge clk);
`endif
        @(negedge clk);
        check("mis_we_cnt", 32'(we_cnt - we0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
